// File: rtl/jtpopeye_dma.sv
// Object-RAM DMA engine.
//
// On a rising edge of vertical blank, requests the main CPU bus. Once the bus is granted, it
// copies main-RAM addresses 0..LAST into object RAM at the same addresses. Every state and
// counter advances only on cpu_cen.
//
// Ports
//   clk, rst_n         : system clock, asynchronous active-low reset
//   cpu_cen            : CPU clock enable
//   VB                 : vertical blank, raw level
//   busrq_n / busak_n  : bus request out / bus acknowledge in, both active low
//   dma_cs             : steers main-RAM addressing to AD_DMA
//   AD_DMA / DD_DMA    : main-RAM read address out; read data in, valid one cpu_cen later
//   obj_addr / obj_din : object-RAM write address and data
//   obj_we             : object-RAM write strobe, already qualified by cpu_cen
//   busy               : high from the trigger until the bus is released
//   chksum             : modulo-256 sum of the bytes written by the last completed transfer
//
// Optional feature: define JTPOPEYE_DMA_CHKSUM_EN to build the checksum accumulator. Without
// it, chksum is tied to zero.

module jtpopeye_dma #(
  parameter logic [9:0] LAST = 10'h3FF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_cen,
  input  logic       VB,
  output logic       busrq_n,
  input  logic       busak_n,
  output logic       dma_cs,
  output logic [9:0] AD_DMA,
  input  logic [7:0] DD_DMA,
  output logic [9:0] obj_addr,
  output logic [7:0] obj_din,
  output logic       obj_we,
  output logic       busy,
  output logic [7:0] chksum
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StXfer,
    StFlush,
    StRel
  } state_e;

  state_e      state_q, state_d;
  logic        vb_q, vb_d;
  logic        armed_q, armed_d;      // cleared by reset so a VB already high cannot trigger
  logic        busrq_q, busrq_d;
  logic        dma_cs_q, dma_cs_d;
  logic        busy_q, busy_d;
  logic [9:0]  ad_q, ad_d;
  logic [9:0]  prev_q, prev_d;        // address whose data is on DD_DMA this cen
  logic        prev_vld_q, prev_vld_d;
  logic [7:0]  hold_q, hold_d;        // data for prev_q, captured when the bus is taken away
  logic        hold_vld_q, hold_vld_d;
  logic        flush_wr_q, flush_wr_d;
  logic [9:0]  obj_addr_q, obj_addr_d;
  logic [7:0]  obj_din_q, obj_din_d;
  logic        we_q, we_d;            // a registered write is pending commit

`ifdef JTPOPEYE_DMA_CHKSUM_EN
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  chksum_q, chksum_d;
`endif

  logic        vb_rise;
  logic        granted;
  logic [7:0]  rd_data;

  assign vb_rise = armed_q & VB & ~vb_q;
  assign granted = ~busak_n;
  // While stalled, the main RAM keeps reading the frozen AD_DMA, so the byte that belongs
  // to prev_q has to come from the capture register on resume.
  assign rd_data = hold_vld_q ? hold_q : DD_DMA;

  always_comb begin
    state_d    = state_q;
    vb_d       = vb_q;
    armed_d    = armed_q;
    busrq_d    = busrq_q;
    dma_cs_d   = dma_cs_q;
    busy_d     = busy_q;
    ad_d       = ad_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    flush_wr_d = flush_wr_q;
    obj_addr_d = obj_addr_q;
    obj_din_d  = obj_din_q;
    we_d       = we_q;
`ifdef JTPOPEYE_DMA_CHKSUM_EN
    acc_d      = acc_q;
    chksum_d   = chksum_q;
`endif

    if (cpu_cen) begin
      vb_d    = VB;
      armed_d = 1'b1;

      unique case (state_q)
        StIdle: begin
          if (vb_rise) begin
            state_d = StReq;
            busrq_d = 1'b0;
            busy_d  = 1'b1;
            ad_d    = 10'd0;
          end
        end

        StReq: begin
          if (granted) begin
            state_d    = StXfer;
            dma_cs_d   = 1'b1;
            ad_d       = 10'd0;
            prev_vld_d = 1'b0;
            hold_vld_d = 1'b0;
            flush_wr_d = 1'b0;
            we_d       = 1'b0;
`ifdef JTPOPEYE_DMA_CHKSUM_EN
            acc_d      = 8'd0;
`endif
          end
        end

        StXfer: begin
          if (!granted) begin
            // Frozen: hold every pipeline register, keep the in-flight byte
            if (!hold_vld_q) begin
              hold_d     = DD_DMA;
              hold_vld_d = 1'b1;
            end
          end else begin
            hold_vld_d = 1'b0;
            we_d       = prev_vld_q;
            if (prev_vld_q) begin
              obj_addr_d = prev_q;
              obj_din_d  = rd_data;
`ifdef JTPOPEYE_DMA_CHKSUM_EN
              acc_d      = acc_q + rd_data;
`endif
            end
            prev_d     = ad_q;
            prev_vld_d = 1'b1;
            // Stop at LAST: the address counter never wraps
            if (ad_q == LAST) begin
              state_d = StFlush;
            end else begin
              ad_d = ad_q + 10'd1;
            end
          end
        end

        StFlush: begin
          if (!granted) begin
            if (!hold_vld_q) begin
              hold_d     = DD_DMA;
              hold_vld_d = 1'b1;
            end
          end else begin
            hold_vld_d = 1'b0;
            if (!flush_wr_q) begin
              // Register the write of LAST
              flush_wr_d = 1'b1;
              we_d       = 1'b1;
              obj_addr_d = prev_q;
              obj_din_d  = rd_data;
`ifdef JTPOPEYE_DMA_CHKSUM_EN
              acc_d      = acc_q + rd_data;
`endif
            end else begin
              // The write of LAST commits on this cen; release the bus
              state_d  = StRel;
              we_d     = 1'b0;
              busrq_d  = 1'b1;
              dma_cs_d = 1'b0;
`ifdef JTPOPEYE_DMA_CHKSUM_EN
              chksum_d = acc_q;
`endif
            end
          end
        end

        StRel: begin
          // Returns to idle without sampling the trigger on this cen
          state_d = StIdle;
          busy_d  = 1'b0;
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      vb_q       <= 1'b0;
      armed_q    <= 1'b0;
      busrq_q    <= 1'b1;
      dma_cs_q   <= 1'b0;
      busy_q     <= 1'b0;
      ad_q       <= 10'd0;
      prev_q     <= 10'd0;
      prev_vld_q <= 1'b0;
      hold_q     <= 8'd0;
      hold_vld_q <= 1'b0;
      flush_wr_q <= 1'b0;
      obj_addr_q <= 10'd0;
      obj_din_q  <= 8'd0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      vb_q       <= vb_d;
      armed_q    <= armed_d;
      busrq_q    <= busrq_d;
      dma_cs_q   <= dma_cs_d;
      busy_q     <= busy_d;
      ad_q       <= ad_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      flush_wr_q <= flush_wr_d;
      obj_addr_q <= obj_addr_d;
      obj_din_q  <= obj_din_d;
      we_q       <= we_d;
    end
  end

`ifdef JTPOPEYE_DMA_CHKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= 8'd0;
      chksum_q <= 8'd0;
    end else begin
      acc_q    <= acc_d;
      chksum_q <= chksum_d;
    end
  end

  assign chksum = chksum_q;
`else
  assign chksum = 8'h00;
`endif

  assign busrq_n  = busrq_q;
  assign dma_cs   = dma_cs_q;
  assign busy     = busy_q;
  assign AD_DMA   = ad_q;
  assign obj_addr = obj_addr_q;
  assign obj_din  = obj_din_q;
  // A pending write commits only on an enabled cycle with the bus still granted
  assign obj_we   = we_q & cpu_cen & ~busak_n;

endmodule

// File: tb/tb_jtpopeye_dma.sv
module tb_jtpopeye_dma;

  localparam logic [9:0] LAST  = 10'h3FF;
  localparam logic [9:0] LAST2 = 10'h00F;

  logic       clk;
  logic       rst_n;
  logic       cpu_cen;
  logic       VB;
  logic       busrq_n;
  logic       busak_n;
  logic       dma_cs;
  logic [9:0] AD_DMA;
  logic [7:0] dd;
  logic [9:0] obj_addr;
  logic [7:0] obj_din;
  logic       obj_we;
  logic       busy;
  logic [7:0] chksum;

  // Second instance with a short transfer, constant RAM data and auto-grant
  logic       VB2;
  logic       busrq2_n;
  logic       busak2_n;
  logic       dma_cs2;
  logic [9:0] AD_DMA2;
  logic [7:0] dd2;
  logic [9:0] obj_addr2;
  logic [7:0] obj_din2;
  logic       obj_we2;
  logic       busy2;
  logic [7:0] chksum2;

  assign busak2_n = busrq2_n;
  assign dd2      = 8'h01;

  jtpopeye_dma #(.LAST(LAST)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_cen  (cpu_cen),
    .VB       (VB),
    .busrq_n  (busrq_n),
    .busak_n  (busak_n),
    .dma_cs   (dma_cs),
    .AD_DMA   (AD_DMA),
    .DD_DMA   (dd),
    .obj_addr (obj_addr),
    .obj_din  (obj_din),
    .obj_we   (obj_we),
    .busy     (busy),
    .chksum   (chksum)
  );

  jtpopeye_dma #(.LAST(LAST2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_cen  (cpu_cen),
    .VB       (VB2),
    .busrq_n  (busrq2_n),
    .busak_n  (busak2_n),
    .dma_cs   (dma_cs2),
    .AD_DMA   (AD_DMA2),
    .DD_DMA   (dd2),
    .obj_addr (obj_addr2),
    .obj_din  (obj_din2),
    .obj_we   (obj_we2),
    .busy     (busy2),
    .chksum   (chksum2)
  );

  typedef struct packed {
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        sb_q[$];
  int         checks;
  int         errors;
  int         wr_total;
  int         wr2_total;
  int         wr_cnt[1024];
  logic       in_gap;
  logic [9:0] exp_a2;
  logic [7:0] ram[1024];
  int         cen_ph;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cpu_cen high on every 4th clk, changed well away from the sampling edge
  always @(posedge clk) begin
    #2;
    cen_ph  = (cen_ph + 1) % 4;
    cpu_cen = (cen_ph == 0);
  end

  // Main RAM: registered read, data valid one cpu_cen after the address
  always @(posedge clk) begin
    if (cpu_cen) dd <= ram[AD_DMA];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon1
    wr_t e;
    if (in_gap) check("gap_no_write", 32'(obj_we), 32'd0);
    if (obj_we === 1'b1) begin
      wr_total++;
      wr_cnt[obj_addr]++;
      check("we_qualified_by_cen", 32'(cpu_cen), 32'd1);
      if (sb_q.size() == 0) begin
        check("unexpected_write", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("wr_addr", 32'(obj_addr), 32'(e.a));
        check("wr_data", 32'(obj_din), 32'(e.d));
      end
    end
  end

  always @(negedge clk) begin
    if (obj_we2 === 1'b1) begin
      wr2_total++;
      check("wr2_addr", 32'(obj_addr2), 32'(exp_a2));
      check("wr2_data", 32'(obj_din2), 32'h01);
      exp_a2 = exp_a2 + 10'd1;
    end
  end

  task automatic cen_tick();
    do @(posedge clk); while (cpu_cen !== 1'b1);
    #1;
  endtask

  // Full transfer on dut: trigger, optional grant delay, optional bus-loss gap at gap_addr,
  // optional extra VB edge at vb_addr.
  task automatic run_xfer(input int grant_delay, input int gap_addr, input int vb_addr);
    int         n;
    int         base;
    logic [7:0] sum;
    logic [7:0] exp_ck;
    wr_t        e;
    bit         gap_done;
    bit         vb_done;
    sum  = 8'd0;
    base = wr_total;
    for (int i = 0; i <= int'(LAST); i++) begin
      e.a = 10'(i);
      e.d = ram[i];
      sb_q.push_back(e);
      sum = sum + ram[i];
    end
    VB = 1'b0;
    cen_tick();
    VB = 1'b1;
    cen_tick();
    check("trig_busrq_n", 32'(busrq_n), 32'd0);
    check("trig_busy", 32'(busy), 32'd1);
    for (int i = 0; i < grant_delay; i++) begin
      cen_tick();
      check("wait_ad_zero", 32'(AD_DMA), 32'd0);
      check("wait_cs_low", 32'(dma_cs), 32'd0);
    end
    check("wait_no_write", 32'(wr_total), 32'(base));
    busak_n  = 1'b0;
    n        = 0;
    gap_done = 1'b0;
    vb_done  = 1'b0;
    while (busrq_n === 1'b0 && n < 3000) begin
      cen_tick();
      n++;
      if (!gap_done && int'(AD_DMA) == gap_addr) begin
        gap_done = 1'b1;
        busak_n  = 1'b1;
        in_gap   = 1'b1;
        for (int k = 0; k < 5; k++) begin
          cen_tick();
          check("gap_ad_frozen", 32'(AD_DMA), 32'(gap_addr));
        end
        in_gap  = 1'b0;
        busak_n = 1'b0;
      end
      if (!vb_done && int'(AD_DMA) == vb_addr) begin
        vb_done = 1'b1;
        VB      = 1'b0;
        cen_tick();
        n++;
        VB = 1'b1;
      end
    end
    // grant cen + 1024 XFER cens + 2 FLUSH cens
    check("rel_cen_count", 32'(n), 32'd1027);
    check("rel_cs_low", 32'(dma_cs), 32'd0);
    check("rel_busy_still", 32'(busy), 32'd1);
    busak_n = 1'b1;
    cen_tick();
    check("idle_busy_low", 32'(busy), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("write_count", 32'(wr_total - base), 32'(int'(LAST) + 1));
    check("ad_no_wrap", 32'(AD_DMA), 32'(LAST));
`ifdef JTPOPEYE_DMA_CHKSUM_EN
    exp_ck = sum;
`else
    exp_ck = 8'h00;
`endif
    check("chksum", 32'(chksum), 32'(exp_ck));
    repeat (4) cen_tick();
    check("no_requeue", 32'(busrq_n), 32'd1);
  endtask

  initial begin : stim
    int         n;
    int         base;
    wr_t        e;
    logic [7:0] exp2;
    checks    = 0;
    errors    = 0;
    wr_total  = 0;
    wr2_total = 0;
    exp_a2    = 10'd0;
    in_gap    = 1'b0;
    cen_ph    = 0;
    cpu_cen   = 1'b0;
    rst_n     = 1'b1;
    VB        = 1'b1;
    VB2       = 1'b0;
    busak_n   = 1'b1;
    for (int i = 0; i < 1024; i++) wr_cnt[i] = 0;

    // Reset values
    #3 rst_n = 1'b0;
    #1;
    check("rst_busrq_n", 32'(busrq_n), 32'd1);
    check("rst_dma_cs", 32'(dma_cs), 32'd0);
    check("rst_ad", 32'(AD_DMA), 32'd0);
    check("rst_obj_addr", 32'(obj_addr), 32'd0);
    check("rst_obj_din", 32'(obj_din), 32'd0);
    check("rst_obj_we", 32'(obj_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_chksum", 32'(chksum), 32'd0);
    #30 rst_n = 1'b1;

    // VB already high at reset release does not trigger
    repeat (8) cen_tick();
    check("vb_high_no_trig_rq", 32'(busrq_n), 32'd1);
    check("vb_high_no_trig_busy", 32'(busy), 32'd0);

    // Incrementing pattern, grant 3 cen late, second VB edge at 0x200 ignored
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i);
    run_xfer(3, -1, 'h200);

    // Long grant delay and a 5-cen bus loss at 0x100
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < 1024; i++) wr_cnt[i] = 0;
    run_xfer(50, 'h100, -1);
    check("once_0ff", 32'(wr_cnt[10'h0FF]), 32'd1);
    check("once_100", 32'(wr_cnt[10'h100]), 32'd1);

    // All-ones data
    for (int i = 0; i < 1024; i++) ram[i] = 8'h01;
    run_xfer(0, -1, -1);

    // Reset mid-transfer at 0x080
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i);
    for (int i = 0; i <= int'(LAST); i++) begin
      e.a = 10'(i);
      e.d = ram[i];
      sb_q.push_back(e);
    end
    VB = 1'b0;
    cen_tick();
    VB = 1'b1;
    cen_tick();
    busak_n = 1'b0;
    n = 0;
    while (AD_DMA !== 10'h080 && n < 500) begin
      cen_tick();
      n++;
    end
    check("rst_mid_reached", 32'(AD_DMA), 32'h080);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busrq_n", 32'(busrq_n), 32'd1);
    check("rst_mid_dma_cs", 32'(dma_cs), 32'd0);
    check("rst_mid_obj_we", 32'(obj_we), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    sb_q.delete();
    busak_n = 1'b1;
    #20 rst_n = 1'b1;
    base = wr_total;
    repeat (20) cen_tick();
    check("post_rst_idle_rq", 32'(busrq_n), 32'd1);
    check("post_rst_idle_cs", 32'(dma_cs), 32'd0);
    check("post_rst_no_write", 32'(wr_total), 32'(base));

    // Short instance, all-ones data
    exp_a2    = 10'd0;
    wr2_total = 0;
    VB2 = 1'b1;
    cen_tick();
    check("dut2_busy", 32'(busy2), 32'd1);
    n = 0;
    while (busy2 === 1'b1 && n < 200) begin
      cen_tick();
      n++;
    end
    check("dut2_done", 32'(busy2), 32'd0);
    check("dut2_writes", 32'(wr2_total), 32'(int'(LAST2) + 1));
    exp2 = 8'd0;
`ifdef JTPOPEYE_DMA_CHKSUM_EN
    for (int i = 0; i <= int'(LAST2); i++) exp2 = exp2 + 8'h01;
`endif
    check("dut2_chksum", 32'(chksum2), 32'(exp2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
